// File: rtl/decode_scan.sv
// rtl/decode_scan.sv - registered N-to-2^N one-hot decoder with auto-scan mode
//
// Purpose: clocked one-hot (or one-cold) decoder. In mode 0 it decodes `a`;
// in mode 1 an internal index steps through every output, dwelling DWELL
// enabled cycles on each one.
//
// Parameters:
//   N          select/index width, 2^N outputs (1..6)
//   DWELL      enabled cycles each output stays active in scan mode (>=1)
//   ACTIVE_LOW 0: selected bit is 1, others 0; 1: all bits inverted
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   en    1 = drive selected output; 0 = all outputs inactive, state held
//   mode  0 = direct decode of `a`; 1 = auto-scan
//   a     address decoded in mode 0
//   y     registered decoded outputs
//   idx   registered index currently selected
//   wrap  one-cycle pulse when the scan index wraps from 2^N-1 to 0
module decode_scan #(
  parameter int N          = 2,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      a,
  output logic [(1<<N)-1:0] y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int M   = 1 << N;
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DMAX     = DCW'(DWELL - 1);
  localparam logic [M-1:0]   INACTIVE = {M{ACTIVE_LOW != 0}};
  localparam logic [M-1:0]   ONE      = M'(1);

  logic [DCW-1:0] dcnt;
  logic [DCW-1:0] dcnt_nxt;
  logic [N-1:0]   idx_nxt;
  logic           wrap_nxt;
  logic [M-1:0]   y_nxt;

  always_comb begin
    dcnt_nxt = dcnt;
    idx_nxt  = idx;
    wrap_nxt = 1'b0;
    y_nxt    = INACTIVE;
    if (en) begin
      if (!mode) begin
        idx_nxt  = a;
        dcnt_nxt = '0;
      end else if (dcnt == DMAX) begin
        // Step edge: advance the index; wrap marks the return to output 0.
        dcnt_nxt = '0;
        idx_nxt  = idx + N'(1);
        wrap_nxt = (idx == {N{1'b1}});
      end else begin
        dcnt_nxt = dcnt + DCW'(1);
      end
      // Decode from the next index so y, idx and wrap always change together.
      y_nxt = (ONE << idx_nxt) ^ INACTIVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      dcnt <= '0;
      wrap <= 1'b0;
      y    <= INACTIVE;
    end else begin
      idx  <= idx_nxt;
      dcnt <= dcnt_nxt;
      wrap <= wrap_nxt;
      y    <= y_nxt;
    end
  end

endmodule

// File: tb/tb_decode_scan.sv
// tb/tb_decode_scan.sv - self-checking bench for decode_scan
module tb_decode_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en1 = 1'b0, mode1 = 1'b0;
  logic [1:0] a1 = '0;
  logic [3:0] y1;
  logic [1:0] idx1;
  logic       wrap1;
  logic       en2 = 1'b0, mode2 = 1'b0;
  logic [2:0] a2 = '0;
  logic [7:0] y2;
  logic [2:0] idx2;
  logic       wrap2;

  int errors = 0;
  int checks = 0;

  decode_scan #(.N(2), .DWELL(3), .ACTIVE_LOW(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .a(a1),
    .y(y1), .idx(idx1), .wrap(wrap1)
  );

  decode_scan #(.N(3), .DWELL(1), .ACTIVE_LOW(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .a(a2),
    .y(y2), .idx(idx2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] a;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  vec_t tbl[$];
  exp_t sb1[$];
  exp_t sb2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic e, input logic m, input logic [1:0] a,
                     input logic [3:0] y, input logic [1:0] i, input logic w);
    vec_t v;
    v.en = e; v.mode = m; v.a = a; v.y = y; v.idx = i; v.wrap = w;
    tbl.push_back(v);
  endtask

  task automatic drive1(input logic e, input logic m, input logic [1:0] a,
                        input logic [3:0] y, input logic [1:0] i, input logic w,
                        input string name);
    exp_t x, got;
    en1 = e; mode1 = m; a1 = a;
    x.y = {4'h0, y}; x.idx = {1'b0, i}; x.wrap = w;
    sb1.push_back(x);
    @(posedge clk); #1;
    got = sb1.pop_front();
    chk({name, ".y"}, {28'h0, y1}, {24'h0, got.y});
    chk({name, ".idx"}, {30'h0, idx1}, {29'h0, got.idx});
    chk({name, ".wrap"}, {31'h0, wrap1}, {31'h0, got.wrap});
  endtask

  task automatic drive2(input logic e, input logic m, input logic [2:0] a,
                        input logic [7:0] y, input logic [2:0] i, input logic w,
                        input string name);
    exp_t x, got;
    en2 = e; mode2 = m; a2 = a;
    x.y = y; x.idx = i; x.wrap = w;
    sb2.push_back(x);
    @(posedge clk); #1;
    got = sb2.pop_front();
    chk({name, ".y"}, {24'h0, y2}, {24'h0, got.y});
    chk({name, ".idx"}, {29'h0, idx2}, {29'h0, got.idx});
    chk({name, ".wrap"}, {31'h0, wrap2}, {31'h0, got.wrap});
    if (en2) chk({name, ".one_zero"}, $countones(~y2), 1);
  endtask

  initial begin
    // Test 1: decode each address
    add(1, 0, 2'd0, 4'b0001, 2'd0, 0);
    add(1, 0, 2'd1, 4'b0010, 2'd1, 0);
    add(1, 0, 2'd2, 4'b0100, 2'd2, 0);
    add(1, 0, 2'd3, 4'b1000, 2'd3, 0);
    add(1, 0, 2'd0, 4'b0001, 2'd0, 0);
    // Test 2: 12 scan cycles from idx 0 (a ignored)
    add(1, 1, 2'd2, 4'b0001, 2'd0, 0);
    add(1, 1, 2'd2, 4'b0001, 2'd0, 0);
    add(1, 1, 2'd2, 4'b0010, 2'd1, 0);
    add(1, 1, 2'd3, 4'b0010, 2'd1, 0);
    add(1, 1, 2'd3, 4'b0010, 2'd1, 0);
    add(1, 1, 2'd3, 4'b0100, 2'd2, 0);
    add(1, 1, 2'd1, 4'b0100, 2'd2, 0);
    add(1, 1, 2'd1, 4'b0100, 2'd2, 0);
    add(1, 1, 2'd1, 4'b1000, 2'd3, 0);
    add(1, 1, 2'd2, 4'b1000, 2'd3, 0);
    add(1, 1, 2'd2, 4'b1000, 2'd3, 0);
    add(1, 1, 2'd2, 4'b0001, 2'd0, 1);
    // Test 3: scan to idx 2, gate en for 5 cycles, resume
    add(1, 1, 2'd0, 4'b0001, 2'd0, 0);
    add(1, 1, 2'd0, 4'b0001, 2'd0, 0);
    add(1, 1, 2'd0, 4'b0010, 2'd1, 0);
    add(1, 1, 2'd0, 4'b0010, 2'd1, 0);
    add(1, 1, 2'd0, 4'b0010, 2'd1, 0);
    add(1, 1, 2'd0, 4'b0100, 2'd2, 0);
    for (int k = 0; k < 5; k++) add(0, 1, 2'd3, 4'b0000, 2'd2, 0);
    add(1, 1, 2'd0, 4'b0100, 2'd2, 0);
    add(1, 1, 2'd0, 4'b0100, 2'd2, 0);
    add(1, 1, 2'd0, 4'b1000, 2'd3, 0);
    // Test 4: decode 3 then scan, then back to decode mid-dwell
    add(1, 0, 2'd3, 4'b1000, 2'd3, 0);
    add(1, 1, 2'd0, 4'b1000, 2'd3, 0);
    add(1, 1, 2'd0, 4'b1000, 2'd3, 0);
    add(1, 1, 2'd0, 4'b0001, 2'd0, 1);
    add(1, 1, 2'd0, 4'b0001, 2'd0, 0);
    add(1, 0, 2'd1, 4'b0010, 2'd1, 0);

    // Reset state, observed before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst.y1", {28'h0, y1}, 32'h0);
    chk("rst.idx1", {30'h0, idx1}, 32'h0);
    chk("rst.wrap1", {31'h0, wrap1}, 32'h0);
    chk("rst.y2", {24'h0, y2}, 32'hff);
    chk("rst.idx2", {29'h0, idx2}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      drive1(tbl[i].en, tbl[i].mode, tbl[i].a, tbl[i].y, tbl[i].idx, tbl[i].wrap,
             $sformatf("vec%0d", i));

    // Test 5: asynchronous reset while idx=3, mid-dwell
    drive1(1, 0, 2'd3, 4'b1000, 2'd3, 0, "ar_dec");
    drive1(1, 1, 2'd0, 4'b1000, 2'd3, 0, "ar_scan");
    #1 rst_n = 1'b0;
    #1;
    chk("ar.y", {28'h0, y1}, 32'h0);
    chk("ar.idx", {30'h0, idx1}, 32'h0);
    chk("ar.wrap", {31'h0, wrap1}, 32'h0);
    #1 rst_n = 1'b1;
    drive1(0, 1, 2'd0, 4'b0000, 2'd0, 0, "ar_off");
    drive1(1, 1, 2'd0, 4'b0001, 2'd0, 0, "ar_s1");
    drive1(1, 1, 2'd0, 4'b0001, 2'd0, 0, "ar_s2");
    drive1(1, 1, 2'd0, 4'b0010, 2'd1, 0, "ar_s3");
    en1 = 1'b0;

    // Test 6: N=3, DWELL=1, ACTIVE_LOW=1 sweep
    drive2(1, 0, 3'd0, 8'hfe, 3'd0, 0, "sw_dec");
    for (int k = 1; k <= 16; k++) begin
      logic [2:0] i;
      logic [7:0] yo;
      i = 3'(k % 8);
      yo = 8'h01 << i;
      drive2(1, 1, 3'd5, ~yo, i, (i == 3'd0), $sformatf("sw%0d", k));
    end
    drive2(0, 1, 3'd0, 8'hff, 3'd0, 0, "sw_off");
    drive2(1, 1, 3'd0, 8'hfd, 3'd1, 0, "sw_resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
